mdu_div_seq: RTL and testbench

- Divide/remainder sequencer for the M extension, directly upstream of the unsigned divide core.
- Accepts DIV/DIVU/REM/REMU from the EX stage and resolves the RISC-V special cases locally.
- Converts signed operands to magnitudes, launches the unsigned core, and applies sign correction to its quotient/remainder.
- Holds the pipeline with stall_o until the result is registered.

---
 rtl/mdu_div_seq.sv | 170 +++++++++++++++++
 tb/tb_mdu_div_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_seq.sv
// mdu_div_seq - divide/remainder sequencer for the RISC-V M extension.
//
// Sits between the EX stage and an unsigned divide core. Handles
// DIV/DIVU/REM/REMU, resolving divide-by-zero and signed overflow
// locally (1-cycle FIX path). All other ops have their operands converted
// to magnitudes, which are handed to the core. The sign of the returned
// quotient/remainder is then corrected.
//
// Optional feature: define MDU_DIV_CACHE_EN to keep the last completed
// rs1/rs2/signedness with its signed q/r. A matching follow-up op (e.g. REM
// after DIV) then completes in one cycle without using the core.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   ce_i                 EX presents a divide-class op (held until valid_o)
//   funct3_i             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_i, rs2_i         dividend, divisor
//   flush_i              abort current op
//   result_o, valid_o    final result and its one-cycle valid pulse
//   stall_o              hold request to the pipeline
//   div_start_o          launch pulse to the unsigned core
//   div_dividend_o       operand magnitude to the core (registered)
//   div_divisor_o        operand magnitude to the core (registered)
//   div_done_i           core completion pulse
//   div_quot_i           unsigned quotient from the core
//   div_rem_i            unsigned remainder from the core
module mdu_div_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ce_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] result_o,
   output logic            valid_o,
   output logic            stall_o,
   output logic            div_start_o,
   output logic [XLEN-1:0] div_dividend_o,
   output logic [XLEN-1:0] div_divisor_o,
   input  logic            div_done_i,
   input  logic [XLEN-1:0] div_quot_i,
   input  logic [XLEN-1:0] div_rem_i
);

   typedef enum logic [2:0] {IDLE, FIX, LAUNCH, WAIT, SIGN} state_t;

   localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t state, state_nxt;

   logic            signed_op, rem_op, accept, div_zero, overflow, special;
   logic            cache_hit;
   logic [XLEN-1:0] special_res, fix_res;
   logic            neg_q, neg_r, is_rem;
   logic [XLEN-1:0] q_signed, r_signed;

   // Two's-complement negate with wrap-around (negating INT_MIN gives INT_MIN).
   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
      return ~x + ONE;
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                 input logic is_signed);
      return (is_signed && x[XLEN-1]) ? negate(x) : x;
   endfunction

   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] x,
                                                  input logic neg);
      return neg ? negate(x) : x;
   endfunction

   assign signed_op = ~funct3_i[0];
   assign rem_op    = funct3_i[1];
   assign accept    = (state == IDLE) & ce_i & funct3_i[2] & ~flush_i;
   assign div_zero  = (rs2_i == '0);
   assign overflow  = signed_op & (rs1_i == INT_MIN) & (rs2_i == '1);
   assign special   = div_zero | overflow;

   // Divide by zero: q = all ones, r = rs1. Overflow: q = rs1, r = 0.
   assign special_res = div_zero ? (rem_op ? rs1_i : '1)
                                 : (rem_op ? '0    : rs1_i);

   assign q_signed = apply_sign(div_quot_i, neg_q);
   assign r_signed = apply_sign(div_rem_i,  neg_r);

`ifdef MDU_DIV_CACHE_EN
   logic            cache_vld, cache_signed;
   logic [XLEN-1:0] cache_rs1, cache_rs2, cache_q, cache_r;

   assign cache_hit = cache_vld & (cache_rs1 == rs1_i) & (cache_rs2 == rs2_i) &
                      (cache_signed == signed_op);
   // Special-case operands never reach the cache, so the two paths never overlap.
   assign fix_res   = special ? special_res : (rem_op ? cache_r : cache_q);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cache_vld <= 1'b0;
      end else if (flush_i) begin
         cache_vld <= 1'b0;
      end else if (accept && !special && !cache_hit) begin
         // The key is overwritten now, so the old entry cannot be trusted.
         cache_vld    <= 1'b0;
         cache_rs1    <= rs1_i;
         cache_rs2    <= rs2_i;
         cache_signed <= signed_op;
      end else if (state == WAIT && div_done_i) begin
         cache_q <= q_signed;
         cache_r <= r_signed;
      end else if (state == SIGN) begin
         cache_vld <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign fix_res   = special_res;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      valid_o     = 1'b0;
      div_start_o = 1'b0;
      case (state)
         IDLE:    if (accept) state_nxt = (special || cache_hit) ? FIX : LAUNCH;
         FIX:     begin valid_o = 1'b1; state_nxt = IDLE; end
         LAUNCH:  begin div_start_o = 1'b1; state_nxt = WAIT; end
         WAIT:    if (div_done_i) state_nxt = SIGN;
         SIGN:    begin valid_o = 1'b1; state_nxt = IDLE; end
         default: state_nxt = IDLE;
      endcase
      if (flush_i) begin
         state_nxt   = IDLE;
         valid_o     = 1'b0;
         div_start_o = 1'b0;
      end
      stall_o = ce_i & ~valid_o & funct3_i[2];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         result_o       <= '0;
         div_dividend_o <= '0;
         div_divisor_o  <= '0;
         neg_q          <= 1'b0;
         neg_r          <= 1'b0;
         is_rem         <= 1'b0;
      end else if (accept) begin
         if (special || cache_hit) begin
            result_o <= fix_res;
         end else begin
            div_dividend_o <= magnitude(rs1_i, signed_op);
            div_divisor_o  <= magnitude(rs2_i, signed_op);
            neg_q          <= signed_op & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_r          <= signed_op & rs1_i[XLEN-1];
            is_rem         <= rem_op;
         end
      end else if (state == WAIT && div_done_i && !flush_i) begin
         result_o <= is_rem ? r_signed : q_signed;
      end
   end

endmodule

// File: tb/tb_mdu_div_seq.sv
module tb_mdu_div_seq;

   logic        clk = 1'b0;
   logic        rst_ni, ce, flush, done;
   logic [2:0]  f3;
   logic [31:0] rs1, rs2, quot, rem;
   logic [31:0] result, dividend, divisor;
   logic        valid, stall, start;

   int checks = 0;
   int errors = 0;

   mdu_div_seq #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .ce_i(ce), .funct3_i(f3),
      .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
      .result_o(result), .valid_o(valid), .stall_o(stall),
      .div_start_o(start), .div_dividend_o(dividend), .div_divisor_o(divisor),
      .div_done_i(done), .div_quot_i(quot), .div_rem_i(rem)
   );

   always #5 clk = ~clk;

   // Presents one op, models the core (done pulse dly cycles after start),
   // and reports what was seen. Cycle 1 is the first cycle after acceptance.
   task automatic exec_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input int dly,
                          output logic [31:0] res, output int starts, output int lat,
                          output logic [31:0] dvd, output logic [31:0] dvs,
                          output bit stall_ok, output bit valid_after);
      int done_at;
      starts = 0; lat = -1; res = '0; dvd = '0; dvs = '0; stall_ok = 1'b1; done_at = -1;
      @(negedge clk); ce = 1'b1; f3 = fn; rs1 = a; rs2 = b; #1;
      if (!stall) stall_ok = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         done = 1'b0;
         if (cyc == done_at) begin done = 1'b1; quot = q; rem = r; end
         #1;
         if (start) begin starts++; dvd = dividend; dvs = divisor; done_at = cyc + dly; end
         if (valid) begin lat = cyc; res = result; break; end
         if (!stall) stall_ok = 1'b0;
      end
      @(negedge clk); ce = 1'b0; done = 1'b0; #1;
      valid_after = valid;
   endtask

   task automatic test_reset;
      @(negedge clk); rst_ni = 1'b0; ce = 1'b0; flush = 1'b0; done = 1'b0;
      f3 = 3'b000; rs1 = '0; rs2 = '0; quot = '0; rem = '0;
      @(negedge clk); @(negedge clk); rst_ni = 1'b1; #1;
      checks++;
      if ({result, dividend, divisor} !== 96'd0 || valid !== 1'b0 || start !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: result=%h dvd=%h dvs=%h valid=%b start=%b required all 0",
                  result, dividend, divisor, valid, start);
      end
   endtask

   task automatic test_not_accepted;
      bit seen;
      seen = 1'b0;
      @(negedge clk); ce = 1'b1; f3 = 3'b001; rs1 = 32'd10; rs2 = 32'd2; #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL non_div_stall: stall=%b required 0", stall); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (valid || start) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL non_div_activity: valid/start seen, required none"); end
      @(negedge clk); ce = 1'b0;
   endtask

   task automatic test_divu;
      logic [31:0] res, dvd, dvs; int starts, lat; bit st_ok, va;
      exec_op(3'b101, 32'd100, 32'd7, 32'd14, 32'd2, 33, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'd14) begin errors++; $display("FAIL divu_result: got %h required %h", res, 32'd14); end
      checks++;
      if (starts !== 1 || dvd !== 32'd100 || dvs !== 32'd7) begin
         errors++; $display("FAIL divu_launch: starts=%0d dvd=%h dvs=%h required 1/64/7", starts, dvd, dvs);
      end
      checks++;
      if (lat !== 35) begin errors++; $display("FAIL divu_latency: got %0d required 35", lat); end
      checks++;
      if (!st_ok) begin errors++; $display("FAIL divu_stall: stall dropped before valid, required held"); end
      checks++;
      if (va !== 1'b0) begin errors++; $display("FAIL divu_valid_pulse: valid=%b a cycle later, required 0", va); end
      // Unsigned: 0x80000000 / 0xFFFFFFFF is not an overflow case and must launch.
      exec_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 3,
              res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'd0 || starts !== 1 || dvd !== 32'h8000_0000 || dvs !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL divu_min_m1: res=%h starts=%0d dvd=%h dvs=%h required 0/1/80000000/ffffffff",
                            res, starts, dvd, dvs);
      end
   endtask

   task automatic test_signed;
      logic [31:0] res, dvd, dvs; int starts, lat; bit st_ok, va;
      exec_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'd3, 32'd1, 5, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_result: got %h required fffffffd", res); end
      checks++;
      if (starts !== 1 || dvd !== 32'd7 || dvs !== 32'd2) begin
         errors++; $display("FAIL div_neg_magnitude: starts=%0d dvd=%h dvs=%h required 1/7/2", starts, dvd, dvs);
      end
      checks++;
      if (lat !== 7) begin errors++; $display("FAIL div_neg_latency: got %0d required 7", lat); end
      exec_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'd3, 32'd1, 5, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg_result: got %h required ffffffff", res); end
   endtask

   task automatic test_special;
      logic [31:0] res, dvd, dvs; int starts, lat; bit st_ok, va;
      logic [2:0]  fns [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 4; i++) begin
         exec_op(fns[i], as[i], bs[i], 32'd0, 32'd0, 2, res, starts, lat, dvd, dvs, st_ok, va);
         checks++;
         if (res !== exp[i] || starts !== 0 || lat !== 1 || va !== 1'b0) begin
            errors++;
            $display("FAIL special_%0d: res=%h starts=%0d lat=%0d valid_after=%b required %h/0/1/0",
                     i, res, starts, lat, va, exp[i]);
         end
      end
   endtask

   task automatic test_reset_in_wait;
      bit seen;
      seen = 1'b0;
      @(negedge clk); ce = 1'b1; f3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
      @(negedge clk); @(negedge clk); @(negedge clk);
      rst_ni = 1'b0; ce = 1'b0;
      @(negedge clk); rst_ni = 1'b1; #1;
      checks++;
      if ({result, dividend, divisor} !== 96'd0 || valid !== 1'b0 || start !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait: result=%h dvd=%h dvs=%h valid=%b start=%b required all 0",
                  result, dividend, divisor, valid, start);
      end
      done = 1'b1; quot = 32'd10; rem = 32'd0;
      @(negedge clk); done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1; if (valid) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL stale_done_after_reset: valid seen, required none"); end
   endtask

   task automatic test_flush;
      logic [31:0] res, dvd, dvs; int starts, lat; bit st_ok, va, seen;
      seen = 1'b0;
      @(negedge clk); ce = 1'b1; f3 = 3'b101; rs1 = 32'd20; rs2 = 32'd4;
      @(negedge clk); @(negedge clk); @(negedge clk);
      // Flush and a core completion in the same cycle: the flush must win.
      flush = 1'b1; done = 1'b1; quot = 32'd5; rem = 32'd0; ce = 1'b0; #1;
      if (valid) seen = 1'b1;
      @(negedge clk); flush = 1'b0; done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1; if (valid) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL flush_no_valid: valid seen, required none"); end
      exec_op(3'b101, 32'd9, 32'd3, 32'd3, 32'd0, 4, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'd3 || starts !== 1 || lat !== 6) begin
         errors++; $display("FAIL after_flush_divu: res=%h starts=%0d lat=%0d required 3/1/6", res, starts, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] res, dvd, dvs; int starts, lat; bit st_ok, va;
      exec_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'd14, 32'd2, 6, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'hFFFF_FFF2 || dvd !== 32'd100 || dvs !== 32'd7) begin
         errors++; $display("FAIL b2b_div: res=%h dvd=%h dvs=%h required fffffff2/64/7", res, dvd, dvs);
      end
      exec_op(3'b110, 32'd100, 32'hFFFF_FFF9, 32'd14, 32'd2, 6, res, starts, lat, dvd, dvs, st_ok, va);
      checks++;
      if (res !== 32'd2) begin errors++; $display("FAIL b2b_rem_result: got %h required 2", res); end
`ifdef MDU_DIV_CACHE_EN
      checks++;
      if (starts !== 0 || lat !== 1) begin
         errors++; $display("FAIL b2b_rem_cached: starts=%0d lat=%0d required 0/1", starts, lat);
      end
`else
      checks++;
      if (starts !== 1 || lat !== 8) begin
         errors++; $display("FAIL b2b_rem_launch: starts=%0d lat=%0d required 1/8", starts, lat);
      end
`endif
   endtask

   initial begin
      rst_ni = 1'b0; ce = 1'b0; flush = 1'b0; done = 1'b0;
      f3 = '0; rs1 = '0; rs2 = '0; quot = '0; rem = '0;
      test_reset();
      test_not_accepted();
      test_divu();
      test_signed();
      test_special();
      test_reset_in_wait();
      test_flush();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
